// File: rtl/pattern_bank_pkg.sv
// pattern_pkg: shared defaults, derived widths and FSM states for the pattern buffer bank
package pattern_pkg;
  localparam int DEF_WORD_W = 8;
  localparam int DEF_NUM_BUF = 8;
  localparam int DEF_BUF_WORDS = 27;
  localparam int DEF_SEQ_LEN = 3;
  localparam int DEF_BA_W = $clog2(DEF_NUM_BUF);
  localparam int DEF_FP_W = $clog2(DEF_BUF_WORDS);
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/pattern_bank_if.sv
// pattern_bank_if: serial load/commit and buffer read bus of the pattern bank
// master drives sin/ssel/saddr/commit/bufp/fieldp; slave drives sout/load_done/err/current_buffer/pattern_sequence
interface pattern_bank_if
  import pattern_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int NUM_BUF = DEF_NUM_BUF,
  parameter int BUF_WORDS = DEF_BUF_WORDS,
  parameter int SEQ_LEN = DEF_SEQ_LEN,
  localparam int BA_W = $clog2(NUM_BUF),
  localparam int FP_W = $clog2(BUF_WORDS)
);
  logic sin, ssel, commit, sout, load_done, err;
  logic [BA_W-1:0] saddr, bufp;
  logic [FP_W-1:0] fieldp;
  logic [WORD_W*BUF_WORDS-1:0] current_buffer;
  logic [WORD_W*SEQ_LEN-1:0] pattern_sequence;
  modport master (
    output sin, ssel, saddr, commit, bufp, fieldp,
    input sout, load_done, err, current_buffer, pattern_sequence
  );
  modport slave (
    input sin, ssel, saddr, commit, bufp, fieldp,
    output sout, load_done, err, current_buffer, pattern_sequence
  );
endinterface

// File: rtl/pattern_bank_window.sv
// pattern_window: registered buffer readout plus SEQ_LEN-word window wrapping at the buffer end
// ports: sclk, rst_n, ok (read select in range), buf_in (word 0 in MSBs), fieldp -> current_buffer, pattern_sequence
module pattern_window
  import pattern_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int BUF_WORDS = DEF_BUF_WORDS,
  parameter int SEQ_LEN = DEF_SEQ_LEN,
  localparam int FP_W = $clog2(BUF_WORDS)
) (
  input logic sclk,
  input logic rst_n,
  input logic ok,
  input logic [WORD_W*BUF_WORDS-1:0] buf_in,
  input logic [FP_W-1:0] fieldp,
  output logic [WORD_W*BUF_WORDS-1:0] current_buffer,
  output logic [WORD_W*SEQ_LEN-1:0] pattern_sequence
);
  localparam logic [FP_W:0] BW = (FP_W+1)'(BUF_WORDS);
  logic [WORD_W-1:0] words [BUF_WORDS];
  logic [WORD_W*SEQ_LEN-1:0] seq_d;
  for (genvar i = 0; i < BUF_WORDS; i++) begin : g_word
    assign words[i] = buf_in[(BUF_WORDS-1-i)*WORD_W +: WORD_W];
  end
  for (genvar k = 0; k < SEQ_LEN; k++) begin : g_seq
    logic [FP_W:0] sum;
    logic [FP_W-1:0] idx;
    assign sum = {1'b0, fieldp} + (FP_W+1)'(k);
    // single compare-and-subtract is enough since fieldp and k are both below BUF_WORDS
    assign idx = FP_W'(sum >= BW ? sum - BW : sum);
    assign seq_d[(SEQ_LEN-1-k)*WORD_W +: WORD_W] = words[idx];
  end
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) begin
      current_buffer <= '0;
      pattern_sequence <= '0;
    end else begin
      current_buffer <= ok ? buf_in : '0;
      pattern_sequence <= ok ? seq_d : '0;
    end
endmodule

// File: rtl/pattern_bank.sv
// pattern_bank: double-buffered pattern bank with serial shadow load, commit and wrapping window read
// ports: sclk, rst_n (async active-low), bus (slave): serial load/commit in, sout/load_done/err out, read select in, read data out
module pattern_bank
  import pattern_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int NUM_BUF = DEF_NUM_BUF,
  parameter int BUF_WORDS = DEF_BUF_WORDS,
  parameter int SEQ_LEN = DEF_SEQ_LEN,
  localparam int BA_W = $clog2(NUM_BUF),
  localparam int FP_W = $clog2(BUF_WORDS)
) (
  input logic sclk,
  input logic rst_n,
  pattern_bank_if.slave bus
);
  localparam int N = WORD_W*BUF_WORDS;
  localparam int CW = $clog2(N);
  logic [N-1:0] shadow [NUM_BUF];
  logic [N-1:0] active [NUM_BUF];
  state_t state, state_d;
  logic [BA_W-1:0] sa_q, tgt;
  logic [CW-1:0] cnt, cur;
  logic sout_q, ld_q, err_q, last, do_commit, bad_commit, ok;
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // the rising-edge shift from IDLE uses saddr and bit 0 directly, later shifts use the latched values
  always_comb begin
    state_d = bus.ssel ? SHIFT : IDLE;
    tgt = state == IDLE ? bus.saddr : sa_q;
    cur = state == IDLE ? '0 : cnt;
    last = cur == CW'(N-1);
    do_commit = state == IDLE && !bus.ssel && bus.commit;
    bad_commit = bus.commit && (state == SHIFT || bus.ssel);
    ok = ({1'b0, bus.bufp} < (BA_W+1)'(NUM_BUF)) && ({1'b0, bus.fieldp} < (FP_W+1)'(BUF_WORDS));
  end
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_BUF; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      sa_q <= '0;
      cnt <= '0;
      sout_q <= 1'b0;
      ld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (bus.ssel) begin
        shadow[tgt] <= {shadow[tgt][N-2:0], bus.sin};
        sout_q <= shadow[tgt][N-1];
        sa_q <= tgt;
        cnt <= last ? '0 : cur + 1'b1;
      end
      if (do_commit) active[bus.saddr] <= shadow[bus.saddr];
      ld_q <= bus.ssel && last;
      err_q <= err_q | bad_commit | !ok;
    end
  assign bus.sout = sout_q;
  assign bus.load_done = ld_q;
  assign bus.err = err_q;
  pattern_window #(.WORD_W(WORD_W), .BUF_WORDS(BUF_WORDS), .SEQ_LEN(SEQ_LEN)) u_window (
    .sclk(sclk),
    .rst_n(rst_n),
    .ok(ok),
    .buf_in(active[bus.bufp]),
    .fieldp(bus.fieldp),
    .current_buffer(bus.current_buffer),
    .pattern_sequence(bus.pattern_sequence)
  );
endmodule

// File: tb/tb_pattern_bank.sv
// tb_pattern_bank: scoreboard bench for pattern_bank with directed load/commit/window/error vectors
module tb_pattern_bank;
  localparam int N = 216;
  localparam int K_CB = 0, K_SEQ = 1, K_ERR = 2, K_LD = 3, K_SOUT = 4;
  typedef struct {int cyc; int kind; string name; logic [N-1:0] exp;} chk_t;
  chk_t sb[$];
  logic sclk = 1'b0, rst_n = 1'b0, ssel_at_edge = 1'b0;
  int cyc = 0, checks = 0, failures = 0, ld_cnt = 0;
  logic [N-1:0] sout_hist = '0, pat, ones;
  always #5 sclk = ~sclk;
  pattern_bank_if bus();
  pattern_bank dut (.sclk(sclk), .rst_n(rst_n), .bus(bus));
  always @(posedge sclk) begin
    cyc <= cyc + 1;
    ssel_at_edge <= bus.ssel;
  end
  always @(negedge sclk) begin
    chk_t c;
    logic [N-1:0] act;
    if (bus.load_done) ld_cnt++;
    if (ssel_at_edge) sout_hist = {sout_hist[N-2:0], bus.sout};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      c = sb.pop_front();
      act = c.kind == K_CB ? N'(bus.current_buffer) : c.kind == K_SEQ ? N'(bus.pattern_sequence) :
            c.kind == K_ERR ? N'(bus.err) : c.kind == K_LD ? N'(ld_cnt) : sout_hist;
      checks++;
      if (act !== c.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end
  task automatic tick();
    @(posedge sclk);
    #2;
  endtask
  task automatic exp_chk(input int kind, input string name, input logic [N-1:0] exp);
    sb.push_back('{cyc, kind, name, exp});
  endtask
  task automatic shift_bits(input logic [2:0] a, input logic [N-1:0] d, input int n);
    bus.saddr = a;
    bus.ssel = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.sin = d[N-1-i];
      tick();
    end
    bus.ssel = 1'b0;
    bus.sin = 1'b0;
    tick();
  endtask
  task automatic do_commit(input logic [2:0] a);
    bus.saddr = a;
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    tick();
  endtask
  initial begin
    bus.sin = 0; bus.ssel = 0; bus.saddr = 0; bus.commit = 0; bus.bufp = 0; bus.fieldp = 0;
    for (int i = 0; i < 27; i++) pat[(26-i)*8 +: 8] = 8'(i + 1);
    ones = '1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    exp_chk(K_CB, "reset_cb", '0);
    exp_chk(K_SEQ, "reset_seq", '0);
    exp_chk(K_ERR, "reset_err", '0);
    exp_chk(K_LD, "reset_ld", '0);
    shift_bits(3'd0, ones, N);
    exp_chk(K_SOUT, "reset_sout", '0);
    exp_chk(K_LD, "first_load_done", N'(1));
    shift_bits(3'd3, pat, N);
    exp_chk(K_SOUT, "load3_sout", '0);
    exp_chk(K_LD, "load3_done", N'(2));
    bus.bufp = 3'd3;
    tick();
    exp_chk(K_CB, "pre_commit_cb", '0);
    bus.saddr = 3'd3;
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    exp_chk(K_CB, "commit_edge_cb", '0);
    tick();
    exp_chk(K_CB, "commit_cb", pat);
    exp_chk(K_SEQ, "seq_f0", N'(24'h010203));
    exp_chk(K_ERR, "commit_err", '0);
    bus.fieldp = 5'd25;
    tick();
    exp_chk(K_SEQ, "seq_f25", N'(24'h1A1B01));
    bus.fieldp = 5'd26;
    tick();
    exp_chk(K_SEQ, "seq_f26", N'(24'h1B0102));
    bus.fieldp = 5'd0;
    tick();
    exp_chk(K_SEQ, "seq_f0_again", N'(24'h010203));
    shift_bits(3'd3, ones, N);
    exp_chk(K_SOUT, "readback_sout", pat);
    exp_chk(K_LD, "readback_done", N'(3));
    exp_chk(K_CB, "active_kept", pat);
    do_commit(3'd3);
    exp_chk(K_CB, "recommit_cb", ones);
    exp_chk(K_SEQ, "recommit_seq", N'(24'hFFFFFF));
    shift_bits(3'd5, ones, 100);
    repeat (3) tick();
    exp_chk(K_LD, "abort_no_done", N'(3));
    exp_chk(K_ERR, "abort_err", '0);
    bus.saddr = 3'd5;
    bus.ssel = 1'b1;
    tick();
    bus.commit = 1'b1;
    tick();
    bus.ssel = 1'b0;
    bus.commit = 1'b0;
    tick();
    exp_chk(K_ERR, "illegal_commit_err", N'(1));
    bus.bufp = 3'd5;
    tick();
    exp_chk(K_CB, "illegal_commit_cb", '0);
    bus.bufp = 3'd3;
    bus.fieldp = 5'd27;
    tick();
    exp_chk(K_CB, "range_cb", '0);
    exp_chk(K_SEQ, "range_seq", '0);
    exp_chk(K_ERR, "range_err", N'(1));
    bus.fieldp = 5'd0;
    bus.saddr = 3'd3;
    bus.ssel = 1'b1;
    bus.sin = 1'b1;
    repeat (50) tick();
    rst_n = 1'b0;
    bus.ssel = 1'b0;
    bus.sin = 1'b0;
    tick();
    exp_chk(K_ERR, "mid_reset_err", '0);
    rst_n = 1'b1;
    tick();
    exp_chk(K_CB, "post_reset_cb", '0);
    exp_chk(K_ERR, "post_reset_err", '0);
    shift_bits(3'd3, pat, N);
    exp_chk(K_SOUT, "post_reset_sout", '0);
    exp_chk(K_LD, "post_reset_done", N'(4));
    do_commit(3'd3);
    exp_chk(K_CB, "post_reset_commit_cb", pat);
    exp_chk(K_SEQ, "post_reset_seq", N'(24'h010203));
    repeat (3) tick();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
